reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Dual-issue register scoreboard sitting directly upstream of the 2-write/4-read register file.
- Tracks outstanding writes per architectural register.
- Tells issue logic whether each of the four source operands (rs1..rs4) can be read from the register file this cycle.
- Watches the same two writeback ports that drive the register file, so "not busy" means the register-file data is current.

Parameters:
- NR_REG, 32: number of architectural registers; register 0 hardwired zero, never tracked.
- CNT_W, 2: width of per-register outstanding-write counter; saturation value 2^CNT_W-1.

Ports:
- clock  in  1  single clock.
- reset  in  1  active-high, asynchronous reset.
- iss_valid  in  1  issue pair presented this cycle.
- iss_wen1  in  1  slot-1 instruction writes a register.
- iss_rd1  in  $clog2(NR_REG)  slot-1 (older) destination.
- iss_wen2  in  1  slot-2 instruction writes a register.
- iss_rd2  in  $clog2(NR_REG)  slot-2 (younger) destination.
- iss_ready  out  1  pair can be accepted without counter saturation.
- rs1, rs2  in  $clog2(NR_REG)  slot-1 source indices.
- rs3, rs4  in  $clog2(NR_REG)  slot-2 source indices.
- rs1_busy..rs4_busy  out  1 each  source not yet valid in register file.
- wen1, rd1  in  1 / $clog2(NR_REG)  writeback port 1, same signals as regfile port 1.
- wen2, rd2  in  1 / $clog2(NR_REG)  writeback port 2, same signals as regfile port 2.
- flush  in  1  pipeline flush; discards all outstanding writes.
- pending  out  $clog2(NR_REG)+CNT_W  total outstanding writes, registered.
- sb_err  out  1  sticky underflow error.

Behaviour:
- State: cnt[r] for r = 1..NR_REG-1, plus pending and sb_err registers.
- Async reset: all cnt = 0, pending = 0, sb_err = 0. Consequently iss_ready = 1 and all busy = 0 during/after reset.
- Effective issue increment inc1 = iss_valid & iss_ready & iss_wen1 & (iss_rd1 != 0); inc2 likewise for slot 2.
- Effective writeback decrement dec1 = wen1 & (rd1 != 0); dec2 likewise.
- Next-edge update: cnt[r] += (inc1 & rd1==r) + (inc2 & rd2==r) - (dec1 & rd1==r) - (dec2 & rd2==r).
  - Increments and decrements in the same cycle net out.
  - Same rd on both issue slots adds 2.
- iss_ready is combinational from cnt, iss_rd*, iss_wen*. It is independent of iss_valid.
  - Low if cnt[rd] + (issue increments to rd) exceeds 2^CNT_W-1 for either slot, ignoring same-cycle decrements.
  - The pair is atomic: both slots accepted or neither.
- Busy query (combinational):
  - rsN_busy = (rsN != 0) & (cnt[rsN] != 0), from registered state.
  - A writeback in cycle t clears busy in t+1, matching register-file write-at-edge timing. There is no same-cycle bypass.
  - Issue in cycle t sets busy in t+1.
- Intra-pair RAW:
  - rs3_busy and rs4_busy additionally assert when iss_valid & iss_wen1 & iss_rd1 != 0 & iss_rd1 == rs3 (resp. rs4).
  - Not gated by iss_ready.
- Underflow: a decrement on a register whose cnt is 0 (after netting) leaves cnt at 0 and sets sb_err. sb_err clears only on reset.
- Flush:
  - At the next edge, all cnt = 0 and pending = 0.
  - Same-cycle issue and writeback are discarded; flush wins.
  - Flush does not set sb_err.
- pending: registered sum of all counters, updated by the same net increments/decrements.
- Reset mid-operation: all state clears immediately (asynchronous); no partial update completes.

Test Plan:
- Reset, then issue iss_rd1=5, wen1 only, no writeback → cycle+1: query rs1=5 gives rs1_busy=1, pending=1. wen1=1, rd1=5 → cycle+1: rs1_busy=0, pending=0.
- Issue pair rd1=rd2=7 → cnt[7]=2. Single writeback rd1=7 → still busy. Second writeback rd2=7 → not busy, pending=0.
- Issue rd1=3 with rs3=3, same cycle → rs3_busy=1 combinationally. rs3=0 or iss_rd1=0 → rs3_busy=0. Register 0 never busy, never counted.
- Fill cnt[9]=3 (CNT_W=2), present iss_rd1=9 → iss_ready=0, no state change. Same-cycle writeback rd1=9 → cnt[9]=2 next cycle, iss_ready=1.
- Writeback rd1=12 while cnt[12]=0 → sb_err=1 and stays 1; cnt[12]=0. Simultaneous issue+writeback to rd 4 at cnt=1 → cnt stays 1.
- Outstanding writes to regs 2, 8, 8, then flush asserted with concurrent issue rd1=6 → next cycle all busy=0, pending=0, cnt[6]=0. Async reset mid-stream clears all before the next edge.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Issue, operand-query, writeback and status signals of the register scoreboard.
// The DUT connects through the slave modport; issue logic / testbench uses master.
interface reg_scoreboard_if #(
  parameter int unsigned NR_REG = 32,
  parameter int unsigned CNT_W  = 2
);
  localparam int unsigned IDX_W  = $clog2(NR_REG);
  localparam int unsigned PEND_W = IDX_W + CNT_W;

  logic              iss_valid;
  logic              iss_wen1;
  logic [IDX_W-1:0]  iss_rd1;
  logic              iss_wen2;
  logic [IDX_W-1:0]  iss_rd2;
  logic              iss_ready;

  logic [IDX_W-1:0]  rs1;
  logic [IDX_W-1:0]  rs2;
  logic [IDX_W-1:0]  rs3;
  logic [IDX_W-1:0]  rs4;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              rs3_busy;
  logic              rs4_busy;

  logic              wen1;
  logic [IDX_W-1:0]  rd1;
  logic              wen2;
  logic [IDX_W-1:0]  rd2;

  logic              flush;
  logic [PEND_W-1:0] pending;
  logic              sb_err;

  modport slave (
    input  iss_valid, iss_wen1, iss_rd1, iss_wen2, iss_rd2,
    input  rs1, rs2, rs3, rs4,
    input  wen1, rd1, wen2, rd2,
    input  flush,
    output iss_ready,
    output rs1_busy, rs2_busy, rs3_busy, rs4_busy,
    output pending, sb_err
  );

  modport master (
    output iss_valid, iss_wen1, iss_rd1, iss_wen2, iss_rd2,
    output rs1, rs2, rs3, rs4,
    output wen1, rd1, wen2, rd2,
    output flush,
    input  iss_ready,
    input  rs1_busy, rs2_busy, rs3_busy, rs4_busy,
    input  pending, sb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Dual-issue register scoreboard: per-register outstanding-write counters updated
// by issue (increment) and the two regfile writeback ports (decrement).
module reg_scoreboard #(
  parameter int unsigned NR_REG = 32,
  parameter int unsigned CNT_W  = 2
) (
  input logic             clock,
  input logic             reset,
  reg_scoreboard_if.slave sb
);
  localparam int unsigned IDX_W  = $clog2(NR_REG);
  localparam int unsigned PEND_W = IDX_W + CNT_W;
  localparam int unsigned SUM_W  = CNT_W + 2;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0]  cnt_q [NR_REG];
  logic [CNT_W-1:0]  cnt_d [NR_REG];
  logic [PEND_W-1:0] pending_q;
  logic [PEND_W-1:0] pending_d;
  logic              sb_err_q;
  logic              sb_err_d;

  logic              add1;
  logic              add2;
  logic              same_rd;
  logic [SUM_W-1:0]  need1;
  logic [SUM_W-1:0]  need2;
  logic              ready;
  logic              inc1;
  logic              inc2;
  logic              dec1;
  logic              dec2;
  logic [SUM_W-1:0]  up;
  logic [SUM_W-1:0]  down;
  logic              raw3;
  logic              raw4;

  // Readiness looks only at issue increments; same-cycle writebacks give no credit.
  always_comb begin
    add1    = sb.iss_wen1 && (sb.iss_rd1 != '0);
    add2    = sb.iss_wen2 && (sb.iss_rd2 != '0);
    same_rd = (sb.iss_rd1 == sb.iss_rd2);
    need1   = SUM_W'(cnt_q[sb.iss_rd1]) + SUM_W'(add1) + SUM_W'(add2 && same_rd);
    need2   = SUM_W'(cnt_q[sb.iss_rd2]) + SUM_W'(add2) + SUM_W'(add1 && same_rd);
    ready   = !((add1 && (need1 > CNT_MAX)) || (add2 && (need2 > CNT_MAX)));
    inc1    = sb.iss_valid && ready && add1;
    inc2    = sb.iss_valid && ready && add2;
    dec1    = sb.wen1 && (sb.rd1 != '0);
    dec2    = sb.wen2 && (sb.rd2 != '0);
  end

  always_comb begin
    cnt_d     = cnt_q;
    pending_d = '0;
    sb_err_d  = sb_err_q;
    up        = '0;
    down      = '0;
    cnt_d[0]  = '0;
    for (int unsigned r = 1; r < NR_REG; r++) begin
      up   = SUM_W'(cnt_q[r])
           + SUM_W'(inc1 && (sb.iss_rd1 == IDX_W'(r)))
           + SUM_W'(inc2 && (sb.iss_rd2 == IDX_W'(r)));
      down = SUM_W'(dec1 && (sb.rd1 == IDX_W'(r)))
           + SUM_W'(dec2 && (sb.rd2 == IDX_W'(r)));
      if (down > up) begin
        cnt_d[r] = '0;
        sb_err_d = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(up - down);
      end
      pending_d = pending_d + PEND_W'(cnt_d[r]);
    end
    // Flush discards everything computed above, including any underflow it would flag.
    if (sb.flush) begin
      cnt_d     = '{default: '0};
      pending_d = '0;
      sb_err_d  = sb_err_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '{default: '0};
      pending_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
    end
  end

  always_comb begin
    raw3 = sb.iss_valid && add1 && (sb.iss_rd1 == sb.rs3);
    raw4 = sb.iss_valid && add1 && (sb.iss_rd1 == sb.rs4);
  end

  assign sb.iss_ready = ready;
  assign sb.rs1_busy  = (sb.rs1 != '0) && (cnt_q[sb.rs1] != '0);
  assign sb.rs2_busy  = (sb.rs2 != '0) && (cnt_q[sb.rs2] != '0);
  assign sb.rs3_busy  = ((sb.rs3 != '0) && (cnt_q[sb.rs3] != '0)) || raw3;
  assign sb.rs4_busy  = ((sb.rs4 != '0) && (cnt_q[sb.rs4] != '0)) || raw4;
  assign sb.pending   = pending_q;
  assign sb.sb_err    = sb_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scenario bench for reg_scoreboard: expected observations are queued as stimulus
// is driven and compared against captured DUT outputs at the end of each scenario.
module tb_reg_scoreboard;
  localparam int unsigned NR_REG = 32;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned PEND_W = $clog2(NR_REG) + CNT_W;

  typedef struct {
    string             tag;
    logic [3:0]        busy;
    logic              ready;
    logic              err;
    logic [PEND_W-1:0] pend;
  } obs_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  obs_t exp_q[$];
  obs_t got_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  reg_scoreboard_if #(.NR_REG(NR_REG), .CNT_W(CNT_W)) sb_if ();

  reg_scoreboard #(.NR_REG(NR_REG), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .sb    (sb_if)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    sb_if.iss_valid = 1'b0; sb_if.iss_wen1 = 1'b0; sb_if.iss_rd1 = '0;
    sb_if.iss_wen2  = 1'b0; sb_if.iss_rd2  = '0;
    sb_if.wen1 = 1'b0; sb_if.rd1 = '0; sb_if.wen2 = 1'b0; sb_if.rd2 = '0;
    sb_if.flush = 1'b0;
  endtask

  task automatic iss(input logic v, input logic w1, input int r1, input logic w2, input int r2);
    sb_if.iss_valid = v;
    sb_if.iss_wen1  = w1; sb_if.iss_rd1 = 5'(r1);
    sb_if.iss_wen2  = w2; sb_if.iss_rd2 = 5'(r2);
  endtask

  task automatic wb(input logic w1, input int r1, input logic w2, input int r2);
    sb_if.wen1 = w1; sb_if.rd1 = 5'(r1);
    sb_if.wen2 = w2; sb_if.rd2 = 5'(r2);
  endtask

  task automatic query(input int a, input int b, input int c, input int d);
    sb_if.rs1 = 5'(a); sb_if.rs2 = 5'(b); sb_if.rs3 = 5'(c); sb_if.rs4 = 5'(d);
  endtask

  // Queue the expected values, then capture what the DUT shows 1 time unit later.
  task automatic observe(input string tag, input logic [3:0] busy, input logic rdy,
                         input logic err, input int pend);
    obs_t e;
    obs_t g;
    e.tag = tag; e.busy = busy; e.ready = rdy; e.err = err; e.pend = PEND_W'(pend);
    exp_q.push_back(e);
    #1;
    g.tag   = tag;
    g.busy  = {sb_if.rs4_busy, sb_if.rs3_busy, sb_if.rs2_busy, sb_if.rs1_busy};
    g.ready = sb_if.iss_ready;
    g.err   = sb_if.sb_err;
    g.pend  = sb_if.pending;
    got_q.push_back(g);
  endtask

  task automatic test_reset();
    obs_t e, g;
    reset = 1'b1; idle(); query(5, 7, 3, 0);
    #2;
    observe("reset_hold", 4'b0000, 1'b1, 1'b0, 0);
    step(); reset = 1'b0;
    observe("reset_release", 4'b0000, 1'b1, 1'b0, 0);
    step();
    observe("post_reset", 4'b0000, 1'b1, 1'b0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin
        n_fail++; $display("FAIL %s: actual=<none> required busy=%b", e.tag, e.busy);
      end else begin
        g = got_q.pop_front();
        if ({g.busy, g.ready, g.err, g.pend} !== {e.busy, e.ready, e.err, e.pend}) begin
          n_fail++;
          $display("FAIL %s: actual busy=%b ready=%b err=%b pending=%0d required busy=%b ready=%b err=%b pending=%0d",
                   e.tag, g.busy, g.ready, g.err, g.pend, e.busy, e.ready, e.err, e.pend);
        end
      end
    end
  endtask

  task automatic test_issue_wb();
    obs_t e, g;
    idle(); query(5, 0, 0, 0);
    iss(1, 1, 5, 0, 0);
    observe("issue5_comb", 4'b0000, 1'b1, 1'b0, 0);
    step(); idle();
    observe("issue5_busy", 4'b0001, 1'b1, 1'b0, 1);
    wb(1, 5, 0, 0);
    observe("wb5_no_bypass", 4'b0001, 1'b1, 1'b0, 1);
    step(); idle();
    observe("wb5_clear", 4'b0000, 1'b1, 1'b0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin
        n_fail++; $display("FAIL %s: actual=<none> required busy=%b", e.tag, e.busy);
      end else begin
        g = got_q.pop_front();
        if ({g.busy, g.ready, g.err, g.pend} !== {e.busy, e.ready, e.err, e.pend}) begin
          n_fail++;
          $display("FAIL %s: actual busy=%b ready=%b err=%b pending=%0d required busy=%b ready=%b err=%b pending=%0d",
                   e.tag, g.busy, g.ready, g.err, g.pend, e.busy, e.ready, e.err, e.pend);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, g;
    idle(); query(7, 0, 7, 0);
    iss(1, 1, 7, 1, 7);
    observe("pair7_raw", 4'b0100, 1'b1, 1'b0, 0);
    step(); idle();
    observe("pair7_cnt2", 4'b0101, 1'b1, 1'b0, 2);
    wb(1, 7, 0, 0);
    step(); idle();
    observe("wb7_first", 4'b0101, 1'b1, 1'b0, 1);
    wb(0, 0, 1, 7);
    step(); idle();
    observe("wb7_second", 4'b0000, 1'b1, 1'b0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin
        n_fail++; $display("FAIL %s: actual=<none> required busy=%b", e.tag, e.busy);
      end else begin
        g = got_q.pop_front();
        if ({g.busy, g.ready, g.err, g.pend} !== {e.busy, e.ready, e.err, e.pend}) begin
          n_fail++;
          $display("FAIL %s: actual busy=%b ready=%b err=%b pending=%0d required busy=%b ready=%b err=%b pending=%0d",
                   e.tag, g.busy, g.ready, g.err, g.pend, e.busy, e.ready, e.err, e.pend);
        end
      end
    end
  endtask

  task automatic test_raw();
    obs_t e, g;
    idle(); query(0, 0, 3, 4);
    iss(1, 1, 3, 0, 0);
    observe("raw_rs3", 4'b0100, 1'b1, 1'b0, 0);
    query(0, 0, 0, 3);
    observe("raw_rs4", 4'b1000, 1'b1, 1'b0, 0);
    query(0, 0, 0, 4);
    observe("raw_rs3_zero", 4'b0000, 1'b1, 1'b0, 0);
    query(0, 0, 3, 3);
    sb_if.iss_valid = 1'b0;
    observe("raw_no_valid", 4'b0000, 1'b1, 1'b0, 0);
    iss(1, 0, 3, 0, 0);
    observe("raw_no_wen", 4'b0000, 1'b1, 1'b0, 0);
    iss(1, 1, 0, 1, 0); query(0, 0, 0, 0);
    observe("raw_rd0", 4'b0000, 1'b1, 1'b0, 0);
    step(); idle();
    observe("reg0_untracked", 4'b0000, 1'b1, 1'b0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin
        n_fail++; $display("FAIL %s: actual=<none> required busy=%b", e.tag, e.busy);
      end else begin
        g = got_q.pop_front();
        if ({g.busy, g.ready, g.err, g.pend} !== {e.busy, e.ready, e.err, e.pend}) begin
          n_fail++;
          $display("FAIL %s: actual busy=%b ready=%b err=%b pending=%0d required busy=%b ready=%b err=%b pending=%0d",
                   e.tag, g.busy, g.ready, g.err, g.pend, e.busy, e.ready, e.err, e.pend);
        end
      end
    end
  endtask

  task automatic test_saturate();
    obs_t e, g;
    idle(); query(9, 10, 0, 0);
    iss(1, 1, 9, 1, 9);
    step();
    iss(1, 1, 9, 0, 0);
    step(); idle();
    observe("fill9", 4'b0001, 1'b1, 1'b0, 3);
    iss(1, 1, 9, 0, 0);
    observe("full9_not_ready", 4'b0001, 1'b0, 1'b0, 3);
    step();
    observe("full9_held", 4'b0001, 1'b0, 1'b0, 3);
    iss(1, 1, 10, 1, 9);
    observe("pair_atomic", 4'b0001, 1'b0, 1'b0, 3);
    step(); idle();
    observe("pair_atomic_held", 4'b0001, 1'b1, 1'b0, 3);
    iss(1, 1, 9, 0, 0); wb(1, 9, 0, 0);
    observe("wb_no_relief", 4'b0001, 1'b0, 1'b0, 3);
    step(); idle();
    iss(0, 1, 9, 0, 0);
    observe("after_wb9_ready", 4'b0001, 1'b1, 1'b0, 2);
    idle(); wb(1, 9, 1, 9);
    step(); idle();
    observe("drain9", 4'b0000, 1'b1, 1'b0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin
        n_fail++; $display("FAIL %s: actual=<none> required busy=%b", e.tag, e.busy);
      end else begin
        g = got_q.pop_front();
        if ({g.busy, g.ready, g.err, g.pend} !== {e.busy, e.ready, e.err, e.pend}) begin
          n_fail++;
          $display("FAIL %s: actual busy=%b ready=%b err=%b pending=%0d required busy=%b ready=%b err=%b pending=%0d",
                   e.tag, g.busy, g.ready, g.err, g.pend, e.busy, e.ready, e.err, e.pend);
        end
      end
    end
  endtask

  task automatic test_flush();
    obs_t e, g;
    idle(); query(2, 8, 6, 0);
    iss(1, 1, 2, 1, 8);
    step();
    iss(1, 1, 8, 0, 0);
    step(); idle();
    observe("pre_flush", 4'b0011, 1'b1, 1'b0, 3);
    iss(1, 1, 6, 0, 0); wb(1, 2, 1, 20); sb_if.flush = 1'b1;
    step(); idle();
    observe("flush_clear", 4'b0000, 1'b1, 1'b0, 0);
    iss(1, 1, 6, 0, 0);
    step(); idle();
    observe("post_flush_issue", 4'b0100, 1'b1, 1'b0, 1);
    wb(1, 6, 0, 0);
    step(); idle();
    observe("post_flush_wb", 4'b0000, 1'b1, 1'b0, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin
        n_fail++; $display("FAIL %s: actual=<none> required busy=%b", e.tag, e.busy);
      end else begin
        g = got_q.pop_front();
        if ({g.busy, g.ready, g.err, g.pend} !== {e.busy, e.ready, e.err, e.pend}) begin
          n_fail++;
          $display("FAIL %s: actual busy=%b ready=%b err=%b pending=%0d required busy=%b ready=%b err=%b pending=%0d",
                   e.tag, g.busy, g.ready, g.err, g.pend, e.busy, e.ready, e.err, e.pend);
        end
      end
    end
  endtask

  task automatic test_underflow();
    obs_t e, g;
    idle(); query(12, 4, 0, 0);
    wb(1, 12, 0, 0);
    step(); idle();
    observe("underflow12", 4'b0000, 1'b1, 1'b1, 0);
    step();
    observe("err_sticky", 4'b0000, 1'b1, 1'b1, 0);
    iss(1, 1, 4, 0, 0);
    step(); idle();
    observe("issue4", 4'b0010, 1'b1, 1'b1, 1);
    iss(1, 1, 4, 0, 0); wb(1, 4, 0, 0);
    step(); idle();
    observe("issue_wb_net4", 4'b0010, 1'b1, 1'b1, 1);
    wb(0, 0, 1, 4);
    step(); idle();
    observe("wb4_clear", 4'b0000, 1'b1, 1'b1, 0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin
        n_fail++; $display("FAIL %s: actual=<none> required busy=%b", e.tag, e.busy);
      end else begin
        g = got_q.pop_front();
        if ({g.busy, g.ready, g.err, g.pend} !== {e.busy, e.ready, e.err, e.pend}) begin
          n_fail++;
          $display("FAIL %s: actual busy=%b ready=%b err=%b pending=%0d required busy=%b ready=%b err=%b pending=%0d",
                   e.tag, g.busy, g.ready, g.err, g.pend, e.busy, e.ready, e.err, e.pend);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t e, g;
    idle(); query(11, 0, 0, 0);
    iss(1, 1, 11, 0, 0);
    step(); idle();
    observe("pre_reset", 4'b0001, 1'b1, 1'b1, 1);
    iss(1, 1, 11, 0, 0);
    #2 reset = 1'b1;
    observe("async_reset", 4'b0000, 1'b1, 1'b0, 0);
    step();
    observe("reset_held_edge", 4'b0000, 1'b1, 1'b0, 0);
    idle(); reset = 1'b0;
    step();
    iss(1, 1, 11, 0, 0);
    step(); idle();
    observe("post_reset_issue", 4'b0001, 1'b1, 1'b0, 1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) begin
        n_fail++; $display("FAIL %s: actual=<none> required busy=%b", e.tag, e.busy);
      end else begin
        g = got_q.pop_front();
        if ({g.busy, g.ready, g.err, g.pend} !== {e.busy, e.ready, e.err, e.pend}) begin
          n_fail++;
          $display("FAIL %s: actual busy=%b ready=%b err=%b pending=%0d required busy=%b ready=%b err=%b pending=%0d",
                   e.tag, g.busy, g.ready, g.err, g.pend, e.busy, e.ready, e.err, e.pend);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_issue_wb();
    test_back_to_back();
    test_raw();
    test_saturate();
    test_flush();
    test_underflow();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
